// File: rtl/clkdiv_pkg.sv
// Shared FSM encoding and default sizing for the runtime-programmable clock divider.
package clkdiv_pkg;

    localparam int CLKDIV_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/clkdiv_period_counter.sv
// Up-counter with a loadable terminal value; at_term flags the last count of a half-period.
// Counts only while run=1 and clears on terminal count or when idle.
module clkdiv_period_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             at_term
);

    // term_val is never zero: the controller rejects a zero divide value
    assign at_term = run && (count == term_val - WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run || at_term) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Runtime-programmable clock divider: q toggles every cur_div cycles, ratio changes and stops
// only take effect at the falling edge of q so every emitted period is complete.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int          WIDTH       = CLKDIV_DEFAULT_WIDTH,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             q,
    output logic             tick,
    output logic             running,
    output logic [WIDTH-1:0] cur_div
);

    state_t           state;
    state_t           state_nxt;
    logic             pending;
    logic [WIDTH-1:0] div_next;
    logic [WIDTH-1:0] count;
    logic             at_term;
    logic             run_st;
    logic             period_end;
    logic             accept;
    logic             cfg_ok;

    assign run_st     = (state != IDLE);
    assign period_end = at_term && q;
    assign accept     = cfg_valid && !pending;
    assign cfg_ok     = accept && (cfg_div != '0);
    assign cfg_ready  = !pending;
    assign running    = run_st;

    clkdiv_period_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .run      (run_st),
        .term_val (cur_div),
        .count    (count),
        .at_term  (at_term)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = period_end ? IDLE : DRAIN;
            DRAIN:   if (period_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            q       <= 1'b0;
            tick    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            tick    <= at_term;
            cfg_err <= accept && (cfg_div == '0);
            if (!run_st) begin
                q <= 1'b0;
            end else if (at_term) begin
                q <= ~q;
            end
        end
    end

    // A ratio accepted on the cycle we drop to IDLE has no later period end, so apply it now
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_div  <= WIDTH'(DEFAULT_DIV);
            div_next <= '0;
            pending  <= 1'b0;
        end else if (!run_st) begin
            if (cfg_ok) cur_div <= cfg_div;
        end else begin
            if (period_end && pending) begin
                cur_div <= div_next;
                pending <= 1'b0;
            end
            if (cfg_ok) begin
                if (period_end && state_nxt == IDLE) begin
                    cur_div <= cfg_div;
                end else begin
                    div_next <= cfg_div;
                    pending  <= 1'b1;
                end
            end
        end
    end

endmodule
